// File: rtl/frame_merge_bridge.sv
// Multi-port store-and-forward frame merger: each ingress port buffers whole frames, commits
// good ones and drops bad or oversized ones; egress forwards committed frames round-robin.
module frame_merge_bridge #(
  parameter int unsigned NPORTS    = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned LEN_DEPTH = 16,
  parameter int unsigned PAUSE_HI  = 1536,
  parameter int unsigned PAUSE_LO  = 512,
  localparam int unsigned PORT_W   = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        in_valid,
  input  logic [NPORTS*DATA_W-1:0] in_data,
  input  logic [NPORTS-1:0]        in_last,
  input  logic [NPORTS-1:0]        in_good,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [PORT_W-1:0]        out_port,
  output logic [15:0]              out_len,
  output logic [NPORTS-1:0]        pause_req,
  output logic [NPORTS*16-1:0]     drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(LEN_DEPTH);
  localparam logic [PW-1:0] FullLvl = PW'(DEPTH);
  localparam logic [PW-1:0] HiLvl   = PW'(PAUSE_HI);
  localparam logic [PW-1:0] LoLvl   = PW'(PAUSE_LO);
  localparam logic [LW:0]   LqFull  = (LW + 1)'(LEN_DEPTH);

  typedef enum logic {StRecv, StDrop} in_state_e;
  typedef enum logic [1:0] {StArb, StLoad, StSend} eg_state_e;

  logic [DATA_W-1:0] mem_q [NPORTS][DEPTH];
  logic [15:0]       len_q [NPORTS][LEN_DEPTH];

  in_state_e   in_st_q [NPORTS];
  in_state_e   in_st_d [NPORTS];
  logic [PW-1:0] wr_ptr_q [NPORTS], wr_ptr_d [NPORTS];
  logic [PW-1:0] cmt_ptr_q [NPORTS], cmt_ptr_d [NPORTS];
  logic [PW-1:0] rd_ptr_q [NPORTS], rd_ptr_d [NPORTS];
  logic [15:0]   fcnt_q [NPORTS], fcnt_d [NPORTS];
  logic [LW:0]   lq_wr_q [NPORTS], lq_wr_d [NPORTS];
  logic [LW:0]   lq_rd_q [NPORTS], lq_rd_d [NPORTS];
  logic [15:0]   drop_q [NPORTS], drop_d [NPORTS];
  logic [NPORTS-1:0] mem_we, lq_we, pause_q, pause_d, avail_q, avail_d;

  eg_state_e         eg_q, eg_d;
  logic [PORT_W-1:0] grant_q, grant_d, port_q, port_d;
  logic [15:0]       olen_q, olen_d, idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Ingress: write, commit or roll back each port's current frame.
  always_comb begin
    logic [PW-1:0] fill;
    logic          full;
    logic          lq_full;
    for (int i = 0; i < NPORTS; i++) begin
      in_st_d[i]   = in_st_q[i];
      wr_ptr_d[i]  = wr_ptr_q[i];
      cmt_ptr_d[i] = cmt_ptr_q[i];
      fcnt_d[i]    = fcnt_q[i];
      lq_wr_d[i]   = lq_wr_q[i];
      drop_d[i]    = drop_q[i];
      mem_we[i]    = 1'b0;
      lq_we[i]     = 1'b0;
      fill    = wr_ptr_q[i] - rd_ptr_q[i];
      full    = (fill == FullLvl);
      lq_full = ((lq_wr_q[i] - lq_rd_q[i]) == LqFull);
      unique case (in_st_q[i])
        StRecv: begin
          if (in_valid[i]) begin
            if (in_last[i]) begin
              fcnt_d[i] = '0;
              if (in_good[i] && !full && !lq_full) begin
                mem_we[i]    = 1'b1;
                lq_we[i]     = 1'b1;
                wr_ptr_d[i]  = wr_ptr_q[i] + PW'(1);
                cmt_ptr_d[i] = wr_ptr_q[i] + PW'(1);
                lq_wr_d[i]   = lq_wr_q[i] + (LW + 1)'(1);
              end else begin
                wr_ptr_d[i] = cmt_ptr_q[i];
                if (drop_q[i] != 16'hFFFF) drop_d[i] = drop_q[i] + 16'd1;
              end
            end else if (full) begin
              wr_ptr_d[i] = cmt_ptr_q[i];
              fcnt_d[i]   = '0;
              in_st_d[i]  = StDrop;
              if (drop_q[i] != 16'hFFFF) drop_d[i] = drop_q[i] + 16'd1;
            end else begin
              mem_we[i]   = 1'b1;
              wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
              fcnt_d[i]   = fcnt_q[i] + 16'd1;
            end
          end
        end
        StDrop: begin
          if (in_valid[i] && in_last[i]) in_st_d[i] = StRecv;
        end
        default: in_st_d[i] = StRecv;
      endcase
      pause_d[i] = pause_q[i];
      if (fill >= HiLvl) begin
        pause_d[i] = 1'b1;
      end else if (fill <= LoLvl) begin
        pause_d[i] = 1'b0;
      end
    end
  end

  // Egress: round-robin arbitration over ports holding a committed frame.
  always_comb begin
    logic              found;
    logic [PORT_W-1:0] cand;
    logic [AW-1:0]     nxt_addr;
    int                p;
    eg_d      = eg_q;
    grant_d   = grant_q;
    port_d    = port_q;
    olen_d    = olen_q;
    idx_d     = idx_q;
    data_d    = data_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    found     = 1'b0;
    cand      = '0;
    nxt_addr  = rd_ptr_q[port_q][AW-1:0] + AW'(1);
    for (int i = 0; i < NPORTS; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      lq_rd_d[i]  = lq_rd_q[i];
      // Registered availability keeps pointer compares out of the arbiter path.
      avail_d[i]  = (lq_wr_q[i] != lq_rd_q[i]);
    end
    for (int k = 1; k <= NPORTS; k++) begin
      p = (int'(grant_q) + k) % int'(NPORTS);
      if (!found && avail_q[p]) begin
        found = 1'b1;
        cand  = PORT_W'(p);
      end
    end
    unique case (eg_q)
      StArb: begin
        if (found) begin
          grant_d = cand;
          eg_d    = StLoad;
        end
      end
      StLoad: begin
        port_d           = grant_q;
        olen_d           = len_q[grant_q][lq_rd_q[grant_q][LW-1:0]];
        lq_rd_d[grant_q] = lq_rd_q[grant_q] + (LW + 1)'(1);
        data_d           = mem_q[grant_q][rd_ptr_q[grant_q][AW-1:0]];
        idx_d            = 16'd1;
        eg_d             = StSend;
      end
      StSend: begin
        out_valid = 1'b1;
        out_last  = (idx_q == olen_q);
        if (out_ready) begin
          rd_ptr_d[port_q] = rd_ptr_q[port_q] + PW'(1);
          if (out_last) begin
            eg_d = StArb;
          end else begin
            idx_d  = idx_q + 16'd1;
            data_d = mem_q[port_q][nxt_addr];
          end
        end
      end
      default: eg_d = StArb;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPORTS; i++) begin
        in_st_q[i]   <= StRecv;
        wr_ptr_q[i]  <= '0;
        cmt_ptr_q[i] <= '0;
        rd_ptr_q[i]  <= '0;
        fcnt_q[i]    <= '0;
        lq_wr_q[i]   <= '0;
        lq_rd_q[i]   <= '0;
        drop_q[i]    <= '0;
      end
      pause_q <= '0;
      avail_q <= '0;
      eg_q    <= StArb;
      grant_q <= PORT_W'(NPORTS - 1);
      port_q  <= '0;
      olen_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        in_st_q[i]   <= in_st_d[i];
        wr_ptr_q[i]  <= wr_ptr_d[i];
        cmt_ptr_q[i] <= cmt_ptr_d[i];
        rd_ptr_q[i]  <= rd_ptr_d[i];
        fcnt_q[i]    <= fcnt_d[i];
        lq_wr_q[i]   <= lq_wr_d[i];
        lq_rd_q[i]   <= lq_rd_d[i];
        drop_q[i]    <= drop_d[i];
      end
      pause_q <= pause_d;
      avail_q <= avail_d;
      eg_q    <= eg_d;
      grant_q <= grant_d;
      port_q  <= port_d;
      olen_q  <= olen_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (mem_we[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= in_data[i*DATA_W +: DATA_W];
      if (lq_we[i]) len_q[i][lq_wr_q[i][LW-1:0]] <= fcnt_q[i] + 16'd1;
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NPORTS; i++) drop_cnt[i*16 +: 16] = drop_q[i];
  end

  assign out_data  = data_q;
  assign out_port  = port_q;
  assign out_len   = olen_q;
  assign pause_req = pause_q;

endmodule

// File: tb/tb_frame_merge_bridge.sv
// Bench for frame_merge_bridge: per-port frame queues as reference, a negedge monitor
// checks every egress byte, length, port and last flag against them.
module tb_frame_merge_bridge;
  localparam int NP    = 2;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] in_valid, in_last, in_good;
  logic [NP*8-1:0] in_data;
  logic          out_valid, out_last, out_ready;
  logic [7:0]    out_data;
  logic [0:0]    out_port;
  logic [15:0]   out_len;
  logic [NP-1:0] pause_req;
  logic [NP*16-1:0] drop_cnt;

  always #5 clk = ~clk;

  frame_merge_bridge #(
    .NPORTS(NP), .DATA_W(8), .DEPTH(DEPTH), .LEN_DEPTH(16), .PAUSE_HI(1536), .PAUSE_LO(512)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_good(in_good), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .out_port(out_port), .out_len(out_len), .pause_req(pause_req),
    .drop_cnt(drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_b [NP][$];
  int         exp_l [NP][$];
  int         exp_drop [NP];
  int         ready_mode = 0;

  bit         in_frame = 0;
  bit         stall_prev = 0;
  int         cur_port, cur_len, idx, drained;
  logic [7:0] held, eb;
  int         start_log [$];

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the edge that samples the last byte.
  task automatic send(input int p, input int len, input bit good, input int dmax,
                      input bit accept);
    logic [7:0] bytes [$];
    logic [7:0] d;
    int gap;
    for (int b = 0; b < len; b++) begin
      gap = (dmax > 0) ? int'($urandom_range(dmax, 0)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      d = 8'($urandom);
      in_valid[p] = 1'b1;
      in_data[p*8 +: 8] = d;
      in_last[p] = (b == len - 1);
      in_good[p] = (b == len - 1) ? good : 1'($urandom);
      bytes.push_back(d);
      @(posedge clk); #1;
      in_valid[p] = 1'b0;
      in_last[p] = 1'b0;
    end
    if (accept) begin
      foreach (bytes[k]) exp_b[p].push_back(bytes[k]);
      exp_l[p].push_back(len);
    end else begin
      exp_drop[p]++;
    end
  endtask

  task automatic send_partial(input int p, input int n);
    for (int b = 0; b < n; b++) begin
      in_valid[p] = 1'b1;
      in_data[p*8 +: 8] = 8'($urandom);
      in_last[p] = 1'b0;
      @(posedge clk); #1;
    end
    in_valid[p] = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int c = 0;
    while ((exp_b[0].size() != 0 || exp_b[1].size() != 0 || in_frame) && c < maxc) begin
      @(posedge clk);
      c++;
    end
    #1;
    check(c < maxc, "drain_timeout", c, maxc);
  endtask

  task automatic wait_idx(input int n, input int maxc);
    int c = 0;
    while (!(in_frame && idx >= n) && c < maxc) begin
      @(posedge clk);
      c++;
    end
    #1;
    check(c < maxc, "idx_timeout", c, maxc);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_frame = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) check(out_valid && out_data == held, "stall_hold", out_data, held);
      if (in_frame) check(out_valid == 1'b1, "valid_midframe", out_valid, 1);
      if (out_valid) begin
        if (!in_frame) begin
          cur_port = int'(out_port);
          start_log.push_back(cur_port);
          check(exp_l[cur_port].size() > 0, "unexpected_frame", cur_port, -1);
          cur_len = (exp_l[cur_port].size() > 0) ? exp_l[cur_port].pop_front() : int'(out_len);
          check(int'(out_len) == cur_len, "out_len", out_len, cur_len);
          idx = 0;
          in_frame = 1;
        end else begin
          check(int'(out_port) == cur_port && int'(out_len) == cur_len, "hdr_hold",
                out_port, cur_port);
        end
        if (out_ready) begin
          if (exp_b[cur_port].size() > 0) begin
            eb = exp_b[cur_port].pop_front();
            check(out_data == eb, "out_data", out_data, eb);
          end else begin
            check(1'b0, "extra_byte", out_data, -1);
          end
          check(out_last == (idx == cur_len - 1), "out_last", out_last, idx == cur_len - 1);
          idx++;
          drained++;
          if (idx >= cur_len) in_frame = 0;
        end
      end
      stall_prev = out_valid && !out_ready;
      held = out_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1, c;
    bit g0, g1;
    rst = 1'b1;
    in_valid = '0; in_data = '0; in_last = '0; in_good = '0;
    exp_drop[0] = 0; exp_drop[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    check(out_last == 1'b0, "rst_out_last", out_last, 0);
    check(out_data == 8'd0, "rst_out_data", out_data, 0);
    check(out_port == 1'b0 && out_len == 16'd0, "rst_port_len", out_len, 0);
    check(pause_req == '0 && drop_cnt == '0, "rst_pause_drop", drop_cnt, 0);
    rst = 1'b0;

    // Same-cycle commits right after reset release: port 0 first, then port 1.
    start_log.delete();
    fork
      send(0, 20, 1'b1, 0, 1'b1);
      send(1, 20, 1'b1, 0, 1'b1);
    join
    wait_drain(500);
    check(start_log.size() == 2, "rr_frames", start_log.size(), 2);
    if (start_log.size() == 2) begin
      check(start_log[0] == 0, "rr_first", start_log[0], 0);
      check(start_log[1] == 1, "rr_second", start_log[1], 1);
    end

    // 64-byte frame latency with egress idle.
    send(0, 64, 1'b1, 0, 1'b1);
    check(out_valid == 1'b0, "lat_T0", out_valid, 0);
    @(posedge clk); #1;
    check(out_valid == 1'b0, "lat_T1", out_valid, 0);
    @(posedge clk); #1;
    check(out_valid == 1'b0, "lat_T2", out_valid, 0);
    @(posedge clk); #1;
    check(out_valid == 1'b1, "lat_T3", out_valid, 1);
    check(out_port == 1'b0 && out_len == 16'd64, "lat_hdr", out_len, 64);
    wait_drain(500);

    // Bad frame dropped, next good frame intact.
    send(0, 100, 1'b0, 0, 1'b0);
    send(0, 30, 1'b1, 0, 1'b1);
    wait_drain(500);
    check(int'(drop_cnt[15:0]) == exp_drop[0], "drop_bad_crc", drop_cnt[15:0], exp_drop[0]);

    // Ten-cycle egress stall mid-frame.
    fork
      send(0, 60, 1'b1, 0, 1'b1);
      begin
        wait_idx(10, 400);
        ready_mode = 2;
        repeat (10) @(posedge clk);
        #1;
        ready_mode = 0;
      end
    join
    wait_drain(500);

    // Randomized traffic on both ports with random backpressure.
    ready_mode = 1;
    repeat (20) begin
      l0 = int'($urandom_range(48, 1)); g0 = ($urandom_range(4) != 0);
      l1 = int'($urandom_range(48, 1)); g1 = ($urandom_range(4) != 0);
      fork
        send(0, l0, g0, 4, g0);
        send(1, l1, g1, 4, g1);
      join
    end
    wait_drain(6000);
    ready_mode = 0;
    check(int'(drop_cnt[15:0]) == exp_drop[0], "rand_drop0", drop_cnt[15:0], exp_drop[0]);
    check(int'(drop_cnt[31:16]) == exp_drop[1], "rand_drop1", drop_cnt[31:16], exp_drop[1]);

    // Fill port 1 to the pause threshold with egress stalled, then drain.
    ready_mode = 2;
    repeat (11) send(1, 128, 1'b1, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check(pause_req[1] == 1'b0, "pause_below_hi", pause_req[1], 0);
    send(1, 128, 1'b1, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check(pause_req[1] == 1'b1, "pause_at_hi", pause_req[1], 1);
    drained = 0;
    ready_mode = 0;
    c = 0;
    while (pause_req[1] && c < 4000) begin
      @(posedge clk); #2;
      c++;
    end
    check(pause_req[1] == 1'b0, "pause_release", pause_req[1], 0);
    check(drained >= 1024 && drained <= 1025, "pause_release_point", drained, 1024);
    wait_drain(3000);

    // Frame longer than the buffer is dropped; the following frame still passes.
    send(1, DEPTH + 10, 1'b1, 0, 1'b0);
    send(1, 40, 1'b1, 0, 1'b1);
    wait_drain(500);
    check(int'(drop_cnt[31:16]) == exp_drop[1], "drop_oversize", drop_cnt[31:16], exp_drop[1]);
    check(pause_req[1] == 1'b0, "pause_after_drop", pause_req[1], 0);

    // Reset during SEND with a partial frame in flight on port 1.
    send(0, 200, 1'b1, 0, 1'b1);
    wait_idx(20, 400);
    send_partial(1, 5);
    #1;
    rst = 1'b1;
    #1;
    check(out_valid == 1'b0, "rst_mid_valid", out_valid, 0);
    check(out_last == 1'b0 && out_len == 16'd0, "rst_mid_len", out_len, 0);
    check(drop_cnt == '0 && pause_req == '0, "rst_mid_cnt", drop_cnt, 0);
    for (int p = 0; p < NP; p++) begin
      exp_b[p].delete();
      exp_l[p].delete();
      exp_drop[p] = 0;
    end
    in_valid = '0; in_last = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(1, 25, 1'b1, 0, 1'b1);
    send(0, 10, 1'b1, 0, 1'b1);
    wait_drain(500);
    repeat (30) @(posedge clk);
    #1;
    check(drop_cnt == '0, "post_reset_drops", drop_cnt, 0);
    check(!in_frame && out_valid == 1'b0, "post_reset_idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
